// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the general-purpose register bank.
// The CPU top uses the same WIDTH/DEPTH constants so decode and writeback agree.
package reg_file_pkg;

    // Default geometry of the CPU register bank.
    localparam int REG_FILE_WIDTH = 32;
    localparam int REG_FILE_DEPTH = 32;

    // Zero-sweep controller states: SWEEP after reset or clear, IDLE otherwise.
    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } sweep_state_t;

endpackage : reg_file_pkg

// File: rtl/reg_file_sweep_ctrl.sv
// Zero-sweep controller for reg_file. After reset, or on a clear request while
// idle, it walks ptr from 0 to DEPTH-1 and writes zero to one entry per cycle.
// busy stays high for exactly DEPTH cycles. A clear seen during a sweep is
// ignored, so the sweep carries on from the current pointer.
module reg_file_sweep_ctrl
    import reg_file_pkg::*;
#(
    parameter int DEPTH  = REG_FILE_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    output logic              busy,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    sweep_state_t      state;
    sweep_state_t      state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nxt;

    // State and pointer register; reset puts the bank back into a fresh sweep.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: clocked state uses <= so every register samples pre-edge values.
        if (!reset) begin
            state <= SWEEP;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Next-state and output decode.
    always_comb begin
        // NOTE: default every output first so no path leaves a value held (no latch).
        state_nxt = state;
        ptr_nxt   = ptr;
        busy      = 1'b0;
        sweep_we  = 1'b0;
        unique case (state)
            SWEEP: begin
                busy     = 1'b1;
                sweep_we = 1'b1;
                if (ptr == LAST_ADDR) begin
                    state_nxt = IDLE;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + ADDR_W'(1);
                end
            end
            IDLE: begin
                if (clear) begin
                    state_nxt = SWEEP;
                    ptr_nxt   = '0;
                end
            end
            default: begin
                state_nxt = SWEEP;
                ptr_nxt   = '0;
            end
        endcase
    end

    assign sweep_addr = ptr;

endmodule : reg_file_sweep_ctrl

// File: rtl/reg_file.sv
// General-purpose register bank: one write port, two combinational read ports,
// optional hardwired-zero entry 0, and a zero sweep after reset or clear.
// Optional feature macro: REG_FILE_BYPASS_EN enables write-first forwarding,
// so a write accepted this cycle appears on a matching read port at once.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH   = REG_FILE_WIDTH,
    parameter int DEPTH   = REG_FILE_DEPTH,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int R0_ZERO = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              clear,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    output logic              busy
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              sweep_we;
    logic [ADDR_W-1:0] sweep_addr;
    logic              port_we;

    reg_file_sweep_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_sweep_ctrl (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .busy       (busy),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr)
    );

    // An address is usable when it names a real entry and is not the
    // hardwired-zero entry.
    function automatic logic addr_usable(input logic [ADDR_W-1:0] a);
        return (int'(a) < DEPTH) && !((R0_ZERO != 0) && (a == '0));
    endfunction

    // Read one port: zero while sweeping or for unusable addresses, stored data
    // otherwise, and the incoming write data when forwarding is built in.
    function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] a);
        logic [WIDTH-1:0] v;
        v = '0;
        if (!busy && addr_usable(a)) begin
            v = mem[a];
        end
`ifdef REG_FILE_BYPASS_EN
        if (port_we && (a == waddr)) begin
            v = wdata;
        end
`endif
        return v;
    endfunction

    // A port write lands only when idle, not overridden by clear, and addressed
    // at a usable entry.
    assign port_we = we && !clear && !busy && addr_usable(waddr);

    // Array write: the sweep owns the write port while busy.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; the sweep zeroes it after reset instead.
        if (sweep_we) begin
            mem[sweep_addr] <= '0;
        end else if (port_we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port A.
    always_comb begin
        rdata_a = read_port(raddr_a);
    end

    // Read port B.
    always_comb begin
        rdata_b = read_port(raddr_b);
    end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file. Instance u0 uses the default geometry
// (DEPTH 32, R0_ZERO 1); instance u1 is DEPTH 12 with R0_ZERO 0. A behavioural
// model (cycles-left counter plus a plain array per instance) predicts busy and
// both read ports, and is compared every falling edge. Directed literal checks
// pin the model. Honours REG_FILE_BYPASS_EN the same way as the design.
module tb_reg_file;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Stimulus per instance (index 0 = u0, 1 = u1).
    logic        in_we    [2];
    int          in_waddr [2];
    logic [31:0] in_wdata [2];
    logic        in_clear [2];
    int          in_ra    [2];
    int          in_rb    [2];

    logic        u0_busy, u1_busy;
    logic [31:0] u0_rdata_a, u0_rdata_b, u1_rdata_a, u1_rdata_b;
    logic [4:0]  u0_waddr, u0_ra, u0_rb;
    logic [3:0]  u1_waddr, u1_ra, u1_rb;

    assign u0_waddr = in_waddr[0][4:0];
    assign u0_ra    = in_ra[0][4:0];
    assign u0_rb    = in_rb[0][4:0];
    assign u1_waddr = in_waddr[1][3:0];
    assign u1_ra    = in_ra[1][3:0];
    assign u1_rb    = in_rb[1][3:0];

    reg_file u0 (
        .clk     (clk),
        .reset   (reset),
        .we      (in_we[0]),
        .waddr   (u0_waddr),
        .wdata   (in_wdata[0]),
        .clear   (in_clear[0]),
        .raddr_a (u0_ra),
        .rdata_a (u0_rdata_a),
        .raddr_b (u0_rb),
        .rdata_b (u0_rdata_b),
        .busy    (u0_busy)
    );

    reg_file #(.WIDTH(32), .DEPTH(12), .R0_ZERO(0)) u1 (
        .clk     (clk),
        .reset   (reset),
        .we      (in_we[1]),
        .waddr   (u1_waddr),
        .wdata   (in_wdata[1]),
        .clear   (in_clear[1]),
        .raddr_a (u1_ra),
        .rdata_a (u1_rdata_a),
        .raddr_b (u1_rb),
        .rdata_b (u1_rdata_b),
        .busy    (u1_busy)
    );

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          depth [2] = '{32, 12};
    bit          r0    [2] = '{1'b1, 1'b0};
    int          m_left[2];
    logic [31:0] m_mem [2][32];

    // Any sweep ends with every entry zero, and reads are forced to zero while
    // it runs, so the model zeroes the whole array at the start.
    task automatic start_sweep(input int i);
        m_left[i] = depth[i];
        for (int a = 0; a < 32; a++) m_mem[i][a] = '0;
    endtask

    function automatic bit accept(input int i);
        return in_we[i] && !in_clear[i] && (m_left[i] == 0) &&
               (in_waddr[i] < depth[i]) && !(r0[i] && in_waddr[i] == 0);
    endfunction

    function automatic logic [31:0] exp_rd(input int i, input int a);
        logic [31:0] v;
        if (m_left[i] != 0 || a >= depth[i] || (r0[i] && a == 0)) v = '0;
        else v = m_mem[i][a];
`ifdef REG_FILE_BYPASS_EN
        if (accept(i) && a == in_waddr[i]) v = in_wdata[i];
`endif
        return v;
    endfunction

    always @(posedge clk or negedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset)               start_sweep(i);
            else if (m_left[i] > 0)   m_left[i]--;
            else if (in_clear[i])     start_sweep(i);
            else if (accept(i))       m_mem[i][in_waddr[i]] = in_wdata[i];
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("u0_busy",    {31'b0, u0_busy}, {31'b0, m_left[0] != 0});
            check("u0_rdata_a", u0_rdata_a, exp_rd(0, in_ra[0]));
            check("u0_rdata_b", u0_rdata_b, exp_rd(0, in_rb[0]));
            check("u1_busy",    {31'b0, u1_busy}, {31'b0, m_left[1] != 0});
            check("u1_rdata_a", u1_rdata_a, exp_rd(1, in_ra[1]));
            check("u1_rdata_b", u1_rdata_b, exp_rd(1, in_rb[1]));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Count rising edges until u0 leaves busy; note when u1 left busy.
    task automatic measure_sweep(output int n0, output int n1);
        n0 = 0;
        n1 = -1;
        @(negedge clk);
        while (u0_busy === 1'b1 && n0 < 100) begin
            @(posedge clk);
            n0++;
            @(negedge clk);
            if (u1_busy !== 1'b1 && n1 < 0) n1 = n0;
        end
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n0, n1, nb;
        for (int i = 0; i < 2; i++) begin
            in_we[i] = 1'b0; in_waddr[i] = 0; in_wdata[i] = '0;
            in_clear[i] = 1'b0; in_ra[i] = 0; in_rb[i] = 0;
        end
        reset = 1'b0;

        // Reset held low for three cycles.
        cyc();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_busy", {31'b0, u0_busy}, 32'd1);
        check("rst_rdata_a", u0_rdata_a, 32'd0);
        cyc();
        cyc();
        reset = 1'b1;
        measure_sweep(n0, n1);
        check("sweep_len", n0, 32);
        check("sweep_len_d12", n1, 12);

        // Writes to 5 and 31, read back on both ports.
        in_we[0] = 1'b1; in_waddr[0] = 5;  in_wdata[0] = 32'hA5A5_A5A5; cyc();
        in_waddr[0] = 31; in_wdata[0] = 32'h5A5A_5A5A; cyc();
        in_we[0] = 1'b0; in_ra[0] = 5; in_rb[0] = 31;
        @(negedge clk);
        check("rd_a_entry5", u0_rdata_a, 32'hA5A5_A5A5);
        check("rd_b_entry31", u0_rdata_b, 32'h5A5A_5A5A);
        cyc();

        // Entry 0: hardwired zero on u0, ordinary register on u1.
        for (int i = 0; i < 2; i++) begin
            in_we[i] = 1'b1; in_waddr[i] = 0; in_wdata[i] = 32'hDEAD_BEEF;
        end
        cyc();
        for (int i = 0; i < 2; i++) begin
            in_we[i] = 1'b0; in_ra[i] = 0;
        end
        @(negedge clk);
        check("r0_zero_read", u0_rdata_a, 32'd0);
        check("r0_plain_read", u1_rdata_a, 32'hDEAD_BEEF);
        cyc();

        // Same-cycle write and read of entry 7.
        in_we[0] = 1'b1; in_waddr[0] = 7; in_wdata[0] = 32'h1234_5678; in_ra[0] = 7;
        @(negedge clk);
`ifdef REG_FILE_BYPASS_EN
        check("bypass_same_cycle", u0_rdata_a, 32'h1234_5678);
`else
        check("no_bypass_old", u0_rdata_a, 32'd0);
`endif
        cyc();
        in_we[0] = 1'b0;
        @(negedge clk);
        check("write_next_cycle", u0_rdata_a, 32'h1234_5678);
        cyc();

        // DEPTH 12: out-of-range address 13 neither stores nor reads.
        in_we[1] = 1'b1; in_waddr[1] = 13; in_wdata[1] = 32'hFFFF_FFFF; in_ra[1] = 13;
        cyc();
        in_we[1] = 1'b0;
        @(negedge clk);
        check("d12_addr13_read", u1_rdata_a, 32'd0);
        cyc();

        // Fill entries 1..31 (u1 wraps into its 12 entries).
        for (int i = 1; i < 32; i++) begin
            in_we[0] = 1'b1; in_waddr[0] = i; in_wdata[0] = 32'h1000_0000 + i * 32'h0001_0101;
            in_we[1] = 1'b1; in_waddr[1] = i % 12; in_wdata[1] = 32'h2000_0000 + i;
            cyc();
        end
        in_we[0] = 1'b0; in_we[1] = 1'b0;
        for (int a = 0; a < 32; a++) begin
            in_ra[0] = a; in_rb[0] = 31 - a; in_ra[1] = a % 16; in_rb[1] = 15 - (a % 16);
            cyc();
        end
        in_ra[0] = 3;
        @(negedge clk);
        check("fill_entry3", u0_rdata_a, 32'h1003_0303);

        // Clear with a simultaneous write to entry 3: clear wins.
        in_clear[0] = 1'b1; in_we[0] = 1'b1; in_waddr[0] = 3; in_wdata[0] = 32'hBAD0_BAD0;
        cyc();
        in_clear[0] = 1'b0; in_waddr[0] = 9; in_wdata[0] = 32'h9999_9999;
        nb = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (u0_busy === 1'b1) nb++;
            cyc();
            if (k == 10) in_clear[0] = 1'b1;
            if (k == 11) in_clear[0] = 1'b0;
        end
        check("clear_busy_cycles", nb, 32);
        in_we[0] = 1'b0; in_ra[0] = 3; in_rb[0] = 9;
        @(negedge clk);
        check("clear_entry3", u0_rdata_a, 32'd0);
        check("idle_write_entry9", u0_rdata_b, 32'h9999_9999);
        cyc();
        for (int a = 0; a < 32; a++) begin
            in_ra[0] = a; in_rb[0] = (a + 16) % 32;
            cyc();
        end

        // Reset at sweep cycle 10 restarts a full sweep.
        in_clear[0] = 1'b1; cyc();
        in_clear[0] = 1'b0;
        repeat (10) cyc();
        reset = 1'b0; cyc();
        reset = 1'b1;
        measure_sweep(n0, n1);
        check("rst_mid_sweep_len", n0, 32);
        check("rst_mid_sweep_len_d12", n1, 12);

        // Reset during a write: the write is lost.
        in_we[0] = 1'b1; in_waddr[0] = 4; in_wdata[0] = 32'hCAFE_F00D;
        in_we[1] = 1'b1; in_waddr[1] = 4; in_wdata[1] = 32'hCAFE_0004;
        @(negedge clk);
        #1 reset = 1'b0;
        cyc();
        in_we[0] = 1'b0; in_we[1] = 1'b0;
        reset = 1'b1;
        measure_sweep(n0, n1);
        check("rst_write_sweep_len", n0, 32);
        in_ra[0] = 4; in_ra[1] = 4;
        @(negedge clk);
        check("rst_write_lost_u0", u0_rdata_a, 32'd0);
        check("rst_write_lost_u1", u1_rdata_a, 32'd0);
        cyc();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_file

// File: doc/reg_file.md
# reg_file

Parametrised multi-entry register file generalising the single 32-bit enable register into the CPU's general-purpose register bank: one write port, two asynchronous read ports, optional hardwired-zero entry 0. After reset, or on a `clear` request, a sweep engine writes zero to every entry, one entry per cycle, and holds `busy` high until done. Sits between the decode stage (reads) and writeback (writes).

## Interface
- `WIDTH`, default 32: data bits per entry.
- `DEPTH`, default 32: number of entries; must be ≥ 2.
- `ADDR_W`, default `$clog2(DEPTH)`: address width; derived, not overridden.
- `R0_ZERO`, default 1: entry 0 always reads 0 and ignores writes.

- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `we`  in  1  write enable.
- `waddr`  in  ADDR_W  write address.
- `wdata`  in  WIDTH  write data.
- `clear`  in  1  request full zero sweep.
- `raddr_a`  in  ADDR_W  read port A address.
- `rdata_a`  out  WIDTH  read port A data, combinational.
- `raddr_b`  in  ADDR_W  read port B address.
- `rdata_b`  out  WIDTH  read port B data, combinational.
- `busy`  out  1  sweep in progress; writes dropped, reads return 0.

## Operation
- Two-state FSM: SWEEP, IDLE. Sweep pointer `ptr` (ADDR_W bits).
- `reset` low: FSM → SWEEP, `ptr` = 0 asynchronously. Array contents not reset directly.
- SWEEP: each edge writes 0 to `mem[ptr]`, `ptr` += 1; on edge where `ptr == DEPTH-1`, FSM → IDLE and `ptr` → 0. Sweep is exactly DEPTH cycles.
- IDLE + `clear` = 1: FSM → SWEEP, `ptr` = 0 next edge; a `we` in the same cycle is dropped (clear wins).
- IDLE + `we` = 1, no `clear`: `mem[waddr] <= wdata`. Dropped if `waddr ≥ DEPTH`, or if `R0_ZERO` and `waddr == 0`.
- SWEEP: `we` ignored; `clear` ignored (sweep continues from current `ptr`, no restart).
- Reads: `rdata_x = mem[raddr_x]`; forced 0 when `busy`, when `raddr_x ≥ DEPTH`, or when `R0_ZERO` and `raddr_x == 0`.
- Both ports may address the same entry; both return the same value.

## Timing
- Outputs during and immediately after reset: `busy` = 1, `rdata_a` = `rdata_b` = 0.
- `busy` falls combinationally with the FSM entering IDLE: first write accepted DEPTH edges after `reset` rises (edge DEPTH+1 counting from the first edge with `reset` high).
- Write latency: value visible on read ports after the capturing edge (same cycle only with bypass).
- `clear` sampled at edge N → `busy` high after edge N, low after edge N+DEPTH.
- `reset` low mid-sweep or mid-write: immediate return to SWEEP, `ptr` = 0; in-flight write lost.

## Configuration
- `REG_FILE_BYPASS_EN` defined: write-first forwarding. In IDLE, if a write will be accepted this cycle (`we`, no `clear`, address valid/not R0) and `raddr_x == waddr`, `rdata_x = wdata` combinationally in the same cycle.
- Undefined: reads return the stored (old) value until after the edge; no forwarding path.

## Structure
- Package `reg_file_pkg`: FSM state typedef (`SWEEP`, `IDLE`), default WIDTH/DEPTH constants shared with the CPU top.
- Sub-module `reg_file_sweep_ctrl`: FSM + `ptr` counter, outputs `busy`, `sweep_we`, `sweep_addr`; top-level muxes sweep writes vs. port writes into the array.

## Test plan
- Reset low 3 cycles, release: `busy` = 1 for 32 edges, `rdata_a` = 0 throughout; `busy` = 0 after edge 32.
- After sweep, write `0xA5A5A5A5` to entry 5, then `0x5A5A5A5A` to entry 31: `raddr_a`=5 → `0xA5A5A5A5`, `raddr_b`=31 → `0x5A5A5A5A` next cycle.
- Write `0xDEADBEEF` to entry 0 with `R0_ZERO`=1: read entry 0 → 0; with `R0_ZERO`=0 → `0xDEADBEEF`.
- `we`=1 to entry 7 with `wdata`=`0x12345678` and `raddr_a`=7 same cycle: bypass build → `0x12345678` that cycle; non-bypass build → old value, then `0x12345678` next cycle.
- Fill entries 1–31, assert `clear` with `we`=1 to entry 3: write dropped, `busy` high 32 cycles, all entries read 0 afterwards; `we` during sweep has no effect.
- Pull `reset` low at sweep cycle 10 and during a write; release: full 32-cycle sweep restarts from entry 0, written entry reads 0. DEPTH=12 build: address 13 read → 0, write dropped, sweep length 12.
